remote_cmd_sched: RTL and testbench

//  Command scheduler in front of RemoteComm. Buffers 16-bit tour commands from a producer
//  (solver, host or bench) and issues them to RemoteComm one at a time.

---
 rtl/remote_cmd_sched.sv | 145 ++++++++++++++
 tb/tb_remote_cmd_sched.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/remote_cmd_sched.sv
// remote_cmd_sched: queues 16-bit tour commands and issues them to
// RemoteComm one at a time with ACK check, timeout and bounded retry.
module remote_cmd_sched #(
  parameter int         DEPTH       = 8,
  parameter logic [7:0] ACK         = 8'hA5,
  parameter int         TIMEOUT_CYC = 2_000_000,
  parameter int         MAX_RETRY   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [15:0]            push_cmd,
  input  logic                   abort,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovfl,
  output logic [15:0]            cmd,
  output logic                   send_cmd,
  input  logic                   cmd_sent,
  input  logic                   resp_rdy,
  input  logic [7:0]             resp,
  output logic                   busy,
  output logic                   cmd_done,
  output logic                   cmd_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] T_MAX  = '1;
  localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRY);
  localparam logic [LW-1:0] L_FULL = LW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE, SEND, WAIT_SENT, WAIT_RESP
  } state_t;

  state_t        state, state_n;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] timer;
  logic [RW-1:0] retry_cnt;
  logic [LW-1:0] level_n;
  logic          pop, fail, timeout, accept;
  logic          load, retry_inc;
  logic          send_n, done_n, err_n;

  assign timeout = (timer == T_LAST);
  // a full FIFO still accepts when the head leaves in the same cycle
  assign accept  = push && (!full || pop);
  assign level_n = level + LW'(accept) - LW'(pop);

  always_comb begin
    state_n   = state;
    pop       = 1'b0;
    fail      = 1'b0;
    load      = 1'b0;
    retry_inc = 1'b0;
    send_n    = 1'b0;
    done_n    = 1'b0;
    err_n     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          state_n = SEND;
          load    = 1'b1;
          send_n  = 1'b1;
        end
      end
      SEND: state_n = WAIT_SENT;
      WAIT_SENT: begin
        if (timeout) fail = 1'b1;
        else if (cmd_sent) state_n = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (resp_rdy && resp == ACK) begin
          pop     = 1'b1;
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (resp_rdy || timeout) begin
          fail = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (fail) begin
      if (retry_cnt < R_MAX) begin
        retry_inc = 1'b1;
        send_n    = 1'b1;
        state_n   = SEND;
      end else begin
        pop     = 1'b1;
        err_n   = 1'b1;
        state_n = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !abort) mem[wr_ptr] <= push_cmd;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      ovfl      <= 1'b0;
      send_cmd  <= 1'b0;
      busy      <= 1'b0;
      cmd_done  <= 1'b0;
      cmd_err   <= 1'b0;
      retry_cnt <= '0;
      timer     <= '0;
      if (!rst_n) cmd <= '0;
    end else begin
      state    <= state_n;
      level    <= level_n;
      full     <= (level_n == L_FULL);
      empty    <= (level_n == '0);
      ovfl     <= push && full && !pop;
      send_cmd <= send_n;
      busy     <= (state_n != IDLE);
      cmd_done <= done_n;
      cmd_err  <= err_n;
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (load) begin
        cmd       <= mem[rd_ptr];
        retry_cnt <= '0;
      end else if (retry_inc) begin
        retry_cnt <= retry_cnt + 1'b1;
      end
      // timer reads 0 in the strobe cycle and counts from there
      if (send_n) timer <= '0;
      else if (state != IDLE && timer != T_MAX) timer <= timer + 1'b1;
    end
  end

endmodule

// File: tb/tb_remote_cmd_sched.sv
// tb_remote_cmd_sched: directed scenarios plus a cycle-level reference
// model of the scheduler contract compared against the DUT every cycle.
module tb_remote_cmd_sched;
  localparam int TO = 1000;
  localparam int DP = 8;
  localparam int MR = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        push = 1'b0;
  logic [15:0] push_cmd = '0;
  logic        abort = 1'b0;
  logic        cmd_sent = 1'b0;
  logic        resp_rdy = 1'b0;
  logic [7:0]  resp = '0;
  logic        full, empty, ovfl, send_cmd, busy, cmd_done, cmd_err;
  logic [3:0]  level;
  logic [15:0] cmd;

  always #5 clk = ~clk;

  remote_cmd_sched #(
    .DEPTH(DP), .ACK(8'hA5), .TIMEOUT_CYC(TO), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .push_cmd(push_cmd),
    .abort(abort), .full(full), .empty(empty), .level(level),
    .ovfl(ovfl), .cmd(cmd), .send_cmd(send_cmd), .cmd_sent(cmd_sent),
    .resp_rdy(resp_rdy), .resp(resp), .busy(busy),
    .cmd_done(cmd_done), .cmd_err(cmd_err)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int nsend = 0;

  // reference model: queue of accepted words plus the in-flight attempt
  logic [15:0] q[$];
  bit          mvalid = 0;
  bit          act, sent;
  int          tries, since;
  bit          e_send, e_done, e_err, e_ovfl;
  logic [15:0] e_cmd;
  bit          m_pop, m_retry, was_act;
  int          sz0;

  always @(posedge clk) begin
    cyc++;
    mvalid = 1;
    e_send = 0; e_done = 0; e_err = 0; e_ovfl = 0;
    if (!rst_n) begin
      q.delete();
      act = 0; sent = 0; tries = 0; since = 0; e_cmd = '0;
    end else if (abort) begin
      q.delete();
      act = 0; sent = 0; tries = 0; since = 0;
    end else begin
      m_pop = 0; m_retry = 0; was_act = act; sz0 = q.size();
      if (act && since > 0) begin
        if (sent && resp_rdy) begin
          if (resp == 8'hA5) begin
            m_pop = 1; e_done = 1; act = 0;
          end else m_retry = 1;
        end else if (since == TO - 1) m_retry = 1;
        else if (!sent && cmd_sent) sent = 1;
      end
      if (m_retry) begin
        if (tries < MR) begin
          tries++; since = 0; sent = 0; e_send = 1;
        end else begin
          m_pop = 1; e_err = 1; act = 0;
        end
      end else if (act) since++;
      if (m_pop) void'(q.pop_front());
      if (push) begin
        if (sz0 < DP || m_pop) q.push_back(push_cmd);
        else e_ovfl = 1;
      end
      if (!was_act && sz0 > 0) begin
        act = 1; since = 0; sent = 0; tries = 0;
        e_send = 1; e_cmd = q[0];
      end
    end
  end

  logic [26:0] got, want;
  always @(negedge clk) begin
    if (mvalid) begin
      got  = {full, empty, level, ovfl, send_cmd, busy,
              cmd_done, cmd_err, cmd};
      want = {q.size() == DP, q.size() == 0, 4'(q.size()), e_ovfl,
              e_send, act, e_done, e_err, e_cmd};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL model cyc=%0d got=%h want=%h", cyc, got, want);
      end
      if (send_cmd === 1'b1) nsend++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] g,
                     input logic [31:0] w);
    total++;
    if (g !== w) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, g, w);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_send(input string nm, input int lim,
                           output int t);
    int n;
    n = 0;
    while (send_cmd !== 1'b1 && n < lim) begin
      step();
      n++;
    end
    t = cyc;
    chk(nm, send_cmd, 1);
  endtask

  // RemoteComm stand-in: usable from the strobe cycle or WAIT_SENT
  task automatic serve(input logic [7:0] r);
    step();
    cmd_sent = 1'b1;
    step();
    cmd_sent = 1'b0;
    step();
    resp_rdy = 1'b1;
    resp = r;
    step();
    resp_rdy = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end

  logic [15:0] w3 [3];
  int t0, t1, t2, n, ov, s0;

  initial begin
    w3[0] = 16'h1111; w3[1] = 16'h2222; w3[2] = 16'h3333;
    repeat (3) step();
    chk("rst_empty", empty, 1);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_send", send_cmd, 0);
    rst_n = 1'b1;
    step();

    // single command, ACK first try
    push = 1'b1; push_cmd = 16'h2A05;
    step();
    push = 1'b0;
    chk("t1_level_in", level, 1);
    wait_send("t1_send", 10, t0);
    chk("t1_cmd", cmd, 16'h2A05);
    serve(8'hA5);
    chk("t1_done", cmd_done, 1);
    chk("t1_level_out", level, 0);
    chk("t1_busy", busy, 0);

    // three queued commands in FIFO order
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; push_cmd = w3[i];
      step();
    end
    push = 1'b0;
    chk("t2_level3", level, 3);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) wait_send("t2_send", 10, t0);
      chk("t2_cmd", cmd, w3[i]);
      chk("t2_level_pre", level, 3 - i);
      serve(8'hA5);
      chk("t2_done", cmd_done, 1);
      chk("t2_level_post", level, 2 - i);
    end

    // NAK, NAK, ACK on one command
    step();
    s0 = nsend;
    push = 1'b1; push_cmd = 16'h1234;
    step();
    push = 1'b0;
    wait_send("t3_send0", 10, t0);
    serve(8'h5A);
    chk("t3_resend1", send_cmd, 1);
    chk("t3_cmd1", cmd, 16'h1234);
    serve(8'h5A);
    chk("t3_resend2", send_cmd, 1);
    serve(8'hA5);
    chk("t3_done", cmd_done, 1);
    chk("t3_noerr", cmd_err, 0);
    chk("t3_nsend", nsend - s0, 3);

    // no response at all: three timed-out attempts then error
    step();
    push = 1'b1; push_cmd = 16'hBEEF;
    step();
    push = 1'b0;
    wait_send("t4_send0", 10, t0);
    step();
    wait_send("t4_send1", TO + 100, t1);
    chk("t4_gap1", t1 - t0, TO);
    step();
    wait_send("t4_send2", TO + 100, t2);
    chk("t4_gap2", t2 - t1, TO);
    n = 0;
    while (cmd_err !== 1'b1 && n < TO + 100) begin
      step();
      n++;
    end
    chk("t4_err_gap", cyc - t2, TO);
    chk("t4_level", level, 0);
    chk("t4_nodone", cmd_done, 0);

    // overflow with no service, then push+pop while full
    step();
    ov = 0;
    for (int i = 0; i < 9; i++) begin
      push = 1'b1; push_cmd = 16'h5000 + 16'(i);
      step();
      ov += int'(ovfl);
    end
    push = 1'b0;
    chk("t5_full", full, 1);
    chk("t5_level8", level, 8);
    chk("t5_ovfl_cnt", ov, 1);
    step();
    chk("t5_ovfl_clr", ovfl, 0);
    cmd_sent = 1'b1;
    step();
    cmd_sent = 1'b0;
    push = 1'b1; push_cmd = 16'h5999;
    resp_rdy = 1'b1; resp = 8'hA5;
    step();
    push = 1'b0; resp_rdy = 1'b0;
    chk("t5_pp_done", cmd_done, 1);
    chk("t5_pp_level", level, 8);
    chk("t5_pp_ovfl", ovfl, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5_abort_empty", empty, 1);

    // abort during WAIT_RESP with four queued
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; push_cmd = 16'hA000 + 16'(i);
      step();
    end
    push = 1'b0;
    cmd_sent = 1'b1;
    step();
    cmd_sent = 1'b0;
    step();
    abort = 1'b1; push = 1'b1; push_cmd = 16'hDEAD;
    step();
    abort = 1'b0; push = 1'b0;
    chk("t6_empty", empty, 1);
    chk("t6_busy", busy, 0);
    chk("t6_level", level, 0);
    chk("t6_send", send_cmd, 0);
    resp_rdy = 1'b1; resp = 8'hA5;
    step();
    resp_rdy = 1'b0;
    chk("t6_nodone", cmd_done, 0);
    repeat (5) step();
    chk("t6_idle", busy, 0);
    chk("t6_still_empty", empty, 1);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
